// File: rtl/spi_host_sequencer.sv
// spi_host_sequencer
//   Master-side sequencer for the SPI RAM slave. Each accepted byte request becomes
//   two 10-bit SPI frames: address then data for writes, read-address then
//   read-data for reads. All pin outputs are registered and follow the FSM state
//   by one cycle.
//
// Parameters
//   IDLE_GAP  cycles SS_n is held high after every frame (1..15)
//   RD_LAT    turnaround cycles before MISO capture on a read-data frame (0..7)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_wr/req_addr/req_wdata latched on accept
//   rsp_valid/rsp_rdata   one-cycle completion pulse and read byte (0x00 after writes)
//   busy                  transaction in progress
//   SS_n, MOSI, MISO      SPI pins
//
// Build option
//   SPI_SEQ_ADDR_CACHE_EN  remember the last write and last read address sent; a
//                          matching request skips its address frame.

module spi_host_sequencer #(
  parameter int unsigned IDLE_GAP = 1,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StSel    = 4'd1;
  localparam logic [3:0] StCmd    = 4'd2;
  localparam logic [3:0] StShift  = 4'd3;
  localparam logic [3:0] StCommit = 4'd4;
  localparam logic [3:0] StTurn   = 4'd5;
  localparam logic [3:0] StCapt   = 4'd6;
  localparam logic [3:0] StGap    = 4'd7;
  localparam logic [3:0] StDone   = 4'd8;

  // Wait counter reload values (count down to zero inclusive).
  localparam logic [3:0] GapInit  = 4'(IDLE_GAP - 1);
  localparam logic [3:0] TurnInit = 4'(RD_LAT - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       frame_idx_q, frame_idx_d;  // 0: address frame, 1: data frame
  logic       wr_q;
  logic [7:0] addr_q, wdata_q;
  logic [7:0] rdata_q, rdata_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       rsp_valid_q;
  logic       accept;
  logic       cache_hit;
  logic       is_rd_data;
  logic [9:0] frame;

  assign req_ready  = (state_q == StIdle);
  assign busy       = !req_ready;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign SS_n       = ss_n_q;
  assign MOSI       = mosi_q;
  assign is_rd_data = !wr_q && frame_idx_q;

  always_comb begin
    case ({wr_q, frame_idx_q})
      2'b10:   frame = {2'b00, addr_q};
      2'b11:   frame = {2'b01, wdata_q};
      2'b00:   frame = {2'b10, addr_q};
      default: frame = {2'b11, 8'h00};
    endcase
  end

`ifdef SPI_SEQ_ADDR_CACHE_EN
  logic [7:0] wr_cache_q, rd_cache_q;
  logic       wr_cache_vld_q, rd_cache_vld_q;

  assign cache_hit = req_wr ? (wr_cache_vld_q && (wr_cache_q == req_addr))
                            : (rd_cache_vld_q && (rd_cache_q == req_addr));

  // Cache only what the slave has actually seen: update once the address frame commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cache_q     <= 8'h00;
      rd_cache_q     <= 8'h00;
      wr_cache_vld_q <= 1'b0;
      rd_cache_vld_q <= 1'b0;
    end else if (state_q == StCommit && !frame_idx_q) begin
      if (wr_q) begin
        wr_cache_q     <= addr_q;
        wr_cache_vld_q <= 1'b1;
      end else begin
        rd_cache_q     <= addr_q;
        rd_cache_vld_q <= 1'b1;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    frame_idx_d = frame_idx_q;
    accept      = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept      = 1'b1;
          frame_idx_d = cache_hit;
          state_d     = StSel;
        end
      end
      StSel: state_d = StCmd;
      StCmd: begin
        state_d   = StShift;
        bit_cnt_d = 4'd9;
      end
      StShift: begin
        if (bit_cnt_q == 4'd0) state_d = StCommit;
        else bit_cnt_d = bit_cnt_q - 4'd1;
      end
      StCommit: begin
        if (is_rd_data) begin
          if (RD_LAT == 0) begin
            state_d   = StCapt;
            bit_cnt_d = 4'd7;
          end else begin
            state_d    = StTurn;
            wait_cnt_d = TurnInit;
          end
        end else begin
          state_d    = StGap;
          wait_cnt_d = GapInit;
        end
      end
      StTurn: begin
        if (wait_cnt_q == 4'd0) begin
          state_d   = StCapt;
          bit_cnt_d = 4'd7;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StCapt: begin
        if (bit_cnt_q == 4'd0) begin
          state_d    = StGap;
          wait_cnt_d = GapInit;
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end
      StGap: begin
        if (wait_cnt_q == 4'd0) begin
          if (!frame_idx_q) begin
            frame_idx_d = 1'b1;
            state_d     = StSel;
          end else begin
            state_d = StDone;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin values derived from the current state, registered so pins lag state by one cycle.
  always_comb begin
    ss_n_d = !(state_q inside {StSel, StCmd, StShift, StCommit, StTurn, StCapt});
    case (state_q)
      StCmd:   mosi_d = frame[9];
      StShift: mosi_d = frame[bit_cnt_q];
      default: mosi_d = 1'b0;
    endcase
    rdata_d = rdata_q;
    if (state_q == StCapt) rdata_d = {rdata_q[6:0], MISO};
    else if (state_q == StDone && wr_q) rdata_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      wait_cnt_q  <= 4'd0;
      frame_idx_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      frame_idx_q <= frame_idx_d;
      rdata_q     <= rdata_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= (state_q == StDone);
      if (accept) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_spi_host_sequencer.sv
`timescale 1ns/1ps
module tb_spi_host_sequencer;

  localparam int IdleGap = 1;
  localparam int RdLat   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_wr = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready, rsp_valid, busy, SS_n, MOSI;
  logic       MISO;
  logic [7:0] rsp_rdata;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_host_sequencer #(
    .IDLE_GAP(IdleGap),
    .RD_LAT  (RdLat)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  // SPI RAM slave model: decodes completed frames, answers read-data frames on MISO.
  logic [7:0] slave_mem [256];
  logic [7:0] slave_ptr = 8'h00;
  logic [7:0] rbyte;
  int         low_cnt = 0;
  logic [9:0] cur_frame = '0;
  logic [9:0] mon_frames[$];
  int         mon_lens[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt   = 0;
      cur_frame = '0;
      MISO      = 1'b0;
    end else if (!SS_n) begin
      if (low_cnt >= 2 && low_cnt <= 11) cur_frame = {cur_frame[8:0], MOSI};
      if (cur_frame[9:8] == 2'b11 && low_cnt >= 12 + RdLat && low_cnt < 20 + RdLat) begin
        rbyte = slave_mem[slave_ptr];
        MISO  = rbyte[7 - (low_cnt - 12 - RdLat)];
      end else begin
        MISO = 1'($urandom);
      end
      low_cnt++;
    end else begin
      MISO = 1'($urandom);
      if (low_cnt != 0) begin
        mon_frames.push_back(cur_frame);
        mon_lens.push_back(low_cnt);
        case (cur_frame[9:8])
          2'b00, 2'b10: slave_ptr = cur_frame[7:0];
          2'b01:        slave_mem[slave_ptr] = cur_frame[7:0];
          default:      ;
        endcase
        low_cnt = 0;
      end
    end
  end

  // Transaction-level reference model.
  logic [7:0] ref_mem [256];
  logic       wc_vld = 1'b0, rc_vld = 1'b0;
  logic [7:0] wc_addr = 8'h00, rc_addr = 8'h00;

  task automatic predict(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         output int nf, output logic [9:0] e0, output logic [9:0] e1,
                         output int el0, output int el1, output int lat,
                         output logic [7:0] rd);
    logic skip;
    logic [9:0] af, df;
    int dlen;
    skip = 1'b0;
`ifdef SPI_SEQ_ADDR_CACHE_EN
    skip = wr ? (wc_vld && wc_addr == addr) : (rc_vld && rc_addr == addr);
    if (wr) begin wc_vld = 1'b1; wc_addr = addr; end
    else begin rc_vld = 1'b1; rc_addr = addr; end
`endif
    if (wr) begin
      af = {2'b00, addr}; df = {2'b01, wdata}; dlen = 13; rd = 8'h00;
      ref_mem[addr] = wdata;
    end else begin
      af = {2'b10, addr}; df = {2'b11, 8'h00}; dlen = 13 + RdLat + 8; rd = ref_mem[addr];
    end
    lat = dlen + IdleGap + 1;
    if (skip) begin
      nf = 1; e0 = df; el0 = dlen; e1 = '0; el1 = 0;
    end else begin
      nf = 2; e0 = af; el0 = 13; e1 = df; el1 = dlen;
      lat = lat + 13 + IdleGap;
    end
  endtask

  task automatic clear_model_cache();
    wc_vld = 1'b0;
    rc_vld = 1'b0;
  endtask

  // Issue one request and wait for its response; gathers observations only.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         output int acc, output int lat, output logic [7:0] rd,
                         output int nf, output logic [9:0] g0, output logic [9:0] g1,
                         output int l0, output int l1, output int viol, output logic after);
    int base, guard;
    base = mon_frames.size();
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    viol = 0; guard = 0;
    while (!rsp_valid && guard < 200) begin
      if (req_ready || !busy) viol++;
      @(negedge clk); guard++;
    end
    lat = rsp_valid ? cyc - acc : -1;
    rd  = rsp_rdata;
    nf  = mon_frames.size() - base;
    g0  = (nf > 0) ? mon_frames[base] : 10'h3ff;
    l0  = (nf > 0) ? mon_lens[base] : -1;
    g1  = (nf > 1) ? mon_frames[base+1] : 10'h3ff;
    l1  = (nf > 1) ? mon_lens[base+1] : -1;
    @(negedge clk);
    after = rsp_valid;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (SS_n !== 1'b1) $display("FAIL reset_ss_n: got %b expected 1", SS_n); else passed++;
    total++; if (MOSI !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", MOSI); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", rsp_rdata); else passed++;
    rst_n = 1'b1;
    clear_model_cache();
    @(negedge clk);
    total++; if (SS_n !== 1'b1) $display("FAIL idle_ss_n: got %b expected 1", SS_n); else passed++;
  endtask

  // Checks one transaction against the model; used by the directed and random scenarios.
  task automatic test_txn(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata);
    int nf, el0, el1, elat, acc, lat, gnf, l0, l1, viol;
    logic [9:0] e0, e1, g0, g1;
    logic [7:0] erd, rd;
    logic after;
    predict(wr, addr, wdata, nf, e0, e1, el0, el1, elat, erd);
    run_txn(wr, addr, wdata, acc, lat, rd, gnf, g0, g1, l0, l1, viol, after);
    total++; if (lat !== elat) $display("FAIL %s latency: got %0d expected %0d", tag, lat, elat); else passed++;
    total++; if (rd !== erd) $display("FAIL %s rdata: got %h expected %h", tag, rd, erd); else passed++;
    total++; if (gnf !== nf) $display("FAIL %s frame_count: got %0d expected %0d", tag, gnf, nf); else passed++;
    total++; if (g0 !== e0) $display("FAIL %s frame0: got %h expected %h", tag, g0, e0); else passed++;
    total++; if (l0 !== el0) $display("FAIL %s frame0_len: got %0d expected %0d", tag, l0, el0); else passed++;
    if (nf == 2) begin
      total++; if (g1 !== e1) $display("FAIL %s frame1: got %h expected %h", tag, g1, e1); else passed++;
      total++; if (l1 !== el1) $display("FAIL %s frame1_len: got %0d expected %0d", tag, l1, el1); else passed++;
    end
    total++; if (viol !== 0) $display("FAIL %s ready_while_busy: got %0d cycles expected 0", tag, viol); else passed++;
    total++; if (after !== 1'b0) $display("FAIL %s rsp_pulse_width: got %b expected 0", tag, after); else passed++;
    total++; if (rsp_rdata !== erd) $display("FAIL %s rdata_hold: got %h expected %h", tag, rsp_rdata, erd); else passed++;
  endtask

  task automatic test_back_to_back();
    int nf, el0, el1, elat1, elat2, acc1, acc2, guard, viol, lat;
    logic [9:0] e0, e1;
    logic [7:0] a1, a2, w2, erd1, erd2, rd1;
    a1 = 8'h60 + 8'($urandom_range(0, 15));
    a2 = 8'h70 + 8'($urandom_range(0, 15));
    w2 = 8'($urandom);
    predict(1'b0, a1, 8'h00, nf, e0, e1, el0, el1, elat1, erd1);
    predict(1'b1, a2, w2, nf, e0, e1, el0, el1, elat2, erd2);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a1; req_wdata = 8'h00;
    guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    acc1 = cyc + 1;
    @(negedge clk);
    req_wr = 1'b1; req_addr = a2; req_wdata = w2;  // held valid while the first runs
    viol = 0; guard = 0;
    while (!rsp_valid && guard < 200) begin
      if (req_ready) viol++;
      @(negedge clk); guard++;
    end
    lat = rsp_valid ? cyc - acc1 : -1;
    rd1 = rsp_rdata;
    guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    acc2 = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (viol !== 0) $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", viol); else passed++;
    total++; if (lat !== elat1) $display("FAIL b2b_first_latency: got %0d expected %0d", lat, elat1); else passed++;
    total++; if (rd1 !== erd1) $display("FAIL b2b_first_rdata: got %h expected %h", rd1, erd1); else passed++;
    total++; if (acc2 - acc1 !== elat1 + 1) $display("FAIL b2b_second_accept: got %0d expected %0d", acc2 - acc1, elat1 + 1); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL b2b_second_taken: got %b expected 0", req_ready); else passed++;
    guard = 0;
    while (!rsp_valid && guard < 200) begin @(negedge clk); guard++; end
    lat = rsp_valid ? cyc - acc2 : -1;
    total++; if (lat !== elat2) $display("FAIL b2b_second_latency: got %0d expected %0d", lat, elat2); else passed++;
    total++; if (rsp_rdata !== 8'h00) $display("FAIL b2b_second_rdata: got %h expected 00", rsp_rdata); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int nf, el0, el1, elat, acc, guard, seen, target;
    logic [9:0] e0, e1;
    logic [7:0] a, w_old, w_drop, erd, saved;
    a = 8'h80 + 8'($urandom_range(0, 63));
    w_old = 8'($urandom);
    w_drop = ~w_old;
    test_txn("pre_reset_wr", 1'b1, a, w_old);
    saved = ref_mem[a];
    predict(1'b1, a, w_drop, nf, e0, e1, el0, el1, elat, erd);
    ref_mem[a] = saved;  // this write is dropped by the reset
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = w_drop;
    guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    target = acc + (elat - 15) + 6;  // middle of the data frame's shift
    guard = 0;
    while (cyc < target && guard < 200) begin @(negedge clk); guard++; end
    total++; if (SS_n !== 1'b0) $display("FAIL mid_reset_in_frame: got SS_n %b expected 0", SS_n); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (SS_n !== 1'b1) $display("FAIL mid_reset_ss_n: got %b expected 1", SS_n); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b expected 1", req_ready); else passed++;
    clear_model_cache();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_reset_no_rsp: got %0d pulses expected 0", seen); else passed++;
    test_txn("post_reset_wr", 1'b1, a, w_old);
    test_txn("post_reset_rd", 1'b0, a, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      slave_mem[i] = b;
      ref_mem[i] = b;
    end
    test_reset();
    test_txn("write_3c", 1'b1, 8'h3C, 8'hA5);
    test_txn("read_3c", 1'b0, 8'h3C, 8'h00);
    test_txn("cache_wr1", 1'b1, 8'h10, 8'h5A);
    test_txn("cache_wr2", 1'b1, 8'h10, 8'hC3);
    test_txn("cache_rd", 1'b0, 8'h10, 8'h00);
    test_back_to_back();
    test_reset_mid_frame();
    for (int i = 0; i < 16; i++) begin
      test_txn("random", 1'($urandom), 8'h50 + 8'($urandom_range(0, 3)), 8'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
